// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, reset-cause
// constants and a constant-evaluable clog2 used to size the counters.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_t;

    localparam logic CAUSE_HW = 1'b0;
    localparam logic CAUSE_SW = 1'b1;

    // Ceiling log2; clog2(1) is 0, clog2(9) is 4.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reset_sequencer_synchronizer.sv
// Reset release synchroniser: asserts asynchronously, releases on the
// DELAY-th rising clock edge after rst falls.
module reset_synchronizer #(
    parameter int DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic [DELAY-1:0] sync_q;

    // Shift zeros in once rst is gone; any rst pulse, however short, sets every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[DELAY-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_q[DELAY-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-output reset sequencer: holds every output asserted for a minimum
// width, then releases them one by one (bit 0 first) at a fixed spacing.
// A software request issued while running restarts the sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 4,
    parameter int STAGE_DELAY = 8
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               sw_rst_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready,
    output logic               sw_cause
);

    localparam int CNT_MAX = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
    localparam int CNT_W   = clog2(CNT_MAX + 1);
    localparam int IDX_W   = clog2(NUM_OUT) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    logic                rst_sync;
    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_OUT-1:0]  rst_out_d;
    logic                ready_d;
    logic                cause_d;

    reset_synchronizer #(
        .DELAY (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst_in),
        .rst_sync (rst_sync)
    );

    // State, counters and registered outputs; rst_in forces everything back to the asserted state.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ASSERT;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_out  <= '1;
            ready    <= 1'b0;
            sw_cause <= CAUSE_HW;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rst_out  <= rst_out_d;
            ready    <= ready_d;
            sw_cause <= cause_d;
        end
    end

    // Sequencing: the hold count starts at one when leaving ASSERT because the
    // synchronised release happened one edge before the FSM could see it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out;
        ready_d   = ready;
        cause_d   = sw_cause;
        case (state_q)
            ASSERT: begin
                if (!rst_sync) begin
                    idx_d = '0;
                    if (MIN_ASSERT == 1) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == REL_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            rst_out_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (sw_rst_req) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    cause_d   = CAUSE_SW;
                end
            end
            default: begin
                state_d = ASSERT;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a minimal-parameter
// instance share stimulus; an edge-number schedule model predicts outputs.
module tb_reset_sequencer;

    localparam int A_N = 4, A_SS = 2, A_MA = 4, A_SD = 8;
    localparam int B_N = 1, B_SS = 3, B_MA = 1, B_SD = 1;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       sw_rst_req;
    logic [3:0] out_a;
    logic       ready_a, cause_a;
    logic [0:0] out_b;
    logic       ready_b, cause_b;

    typedef struct {
        logic [3:0] out_a;
        logic       ready_a;
        logic       cause_a;
        logic       out_b;
        logic       ready_b;
        logic       cause_b;
    } exp_t;

    exp_t exp_q[$];

    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_no     = 0;
    int   base_a      = 1 << 30;
    int   base_b      = 1 << 30;
    logic cause_ma    = 1'b0;
    logic cause_mb    = 1'b0;
    logic prev_rin    = 1'b1;
    logic glitch      = 1'b0;

    reset_sequencer #(
        .NUM_OUT(A_N), .SYNC_STAGES(A_SS), .MIN_ASSERT(A_MA), .STAGE_DELAY(A_SD)
    ) dut_a (
        .clk(clk), .rst_in(rst_in), .sw_rst_req(sw_rst_req),
        .rst_out(out_a), .ready(ready_a), .sw_cause(cause_a)
    );

    reset_sequencer #(
        .NUM_OUT(B_N), .SYNC_STAGES(B_SS), .MIN_ASSERT(B_MA), .STAGE_DELAY(B_SD)
    ) dut_b (
        .clk(clk), .rst_in(rst_in), .sw_rst_req(sw_rst_req),
        .rst_out(out_b), .ready(ready_b), .sw_cause(cause_b)
    );

    always #5 clk = ~clk;

    // Bit i is still asserted at edge n until edge base + (i+1)*sd.
    function automatic logic [15:0] modelBits(input int n, input int base, input int nout, input int sd);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < nout; i++) begin
            r[i] = (n < base + (i + 1) * sd);
        end
        return r;
    endfunction

    function automatic logic isThermo(input logic [3:0] v);
        for (int i = 1; i < 4; i++) begin
            if (v[i-1] && !v[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_no, act, exp);
        end
    endtask

    // Drive inputs for the next edge and push what both instances should show after it.
    task automatic applyStimulus(input logic rin, input logic req);
        exp_t        e;
        logic        fresh;
        logic [15:0] bits;
        rst_in     = rin;
        sw_rst_req = req;
        edge_no++;
        fresh = prev_rin || glitch;
        if (rin) begin
            cause_ma = 1'b0;
            cause_mb = 1'b0;
        end else if (fresh) begin
            base_a   = edge_no - 1 + A_SS + A_MA;
            base_b   = edge_no - 1 + B_SS + B_MA;
            cause_ma = 1'b0;
            cause_mb = 1'b0;
        end else begin
            if (req && (edge_no - 1 >= base_a + A_N * A_SD)) begin
                cause_ma = 1'b1;
                base_a   = edge_no + A_MA;
            end
            if (req && (edge_no - 1 >= base_b + B_N * B_SD)) begin
                cause_mb = 1'b1;
                base_b   = edge_no + B_MA;
            end
        end
        bits      = modelBits(edge_no, base_a, A_N, A_SD);
        e.out_a   = rin ? 4'hF : bits[3:0];
        e.ready_a = !rin && (edge_no >= base_a + A_N * A_SD);
        e.cause_a = cause_ma;
        bits      = modelBits(edge_no, base_b, B_N, B_SD);
        e.out_b   = rin ? 1'b1 : bits[0];
        e.ready_b = !rin && (edge_no >= base_b + B_N * B_SD);
        e.cause_b = cause_mb;
        exp_q.push_back(e);
        prev_rin = rin;
        glitch   = 1'b0;
    endtask

    task automatic compareOutputs();
        exp_t e;
        checkOutput("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("a_rst_out", out_a, e.out_a);
            checkOutput("a_ready", ready_a, e.ready_a);
            checkOutput("a_sw_cause", cause_a, e.cause_a);
            checkOutput("a_thermo", isThermo(out_a), 1);
            checkOutput("b_rst_out", out_b, e.out_b);
            checkOutput("b_ready", ready_b, e.ready_b);
            checkOutput("b_sw_cause", cause_b, e.cause_b);
        end
    endtask

    task automatic runCycle(input logic rin, input logic req);
        applyStimulus(rin, req);
        @(negedge clk);
        compareOutputs();
    endtask

    task automatic checkAsserted(input string tag);
        checkOutput({tag, "_a_out"}, out_a, 4'hF);
        checkOutput({tag, "_a_ready"}, ready_a, 0);
        checkOutput({tag, "_a_cause"}, cause_a, 0);
        checkOutput({tag, "_b_out"}, out_b, 1);
        checkOutput({tag, "_b_ready"}, ready_b, 0);
        checkOutput({tag, "_b_cause"}, cause_b, 0);
    endtask

    initial begin
        rst_in     = 1'b1;
        sw_rst_req = 1'b0;

        $display("[TB] power-on sequence, ignored request at 25, software reset at 50");
        runCycle(1'b1, 1'b0);
        runCycle(1'b1, 1'b0);
        for (int e = 1; e <= 95; e++) begin
            runCycle(1'b0, (e == 25) || (e == 50));
        end

        $display("[TB] hardware reset, then asynchronous reset mid-sequence");
        runCycle(1'b1, 1'b0);
        runCycle(1'b1, 1'b0);
        for (int e = 1; e <= 26; e++) begin
            runCycle(1'b0, 1'b0);
        end
        rst_in = 1'b1;
        #1;
        checkAsserted("async");
        runCycle(1'b1, 1'b0);
        runCycle(1'b1, 1'b0);
        for (int e = 1; e <= 85; e++) begin
            runCycle(1'b0, e == 40);
        end

        $display("[TB] short rst_in glitch while running");
        rst_in = 1'b1;
        #3;
        rst_in = 1'b0;
        glitch = 1'b1;
        #1;
        checkAsserted("glitch");
        for (int e = 1; e <= 45; e++) begin
            runCycle(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
